alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
Clocked controller that sequences a user ALU session on the DE10 board: operation selection, operand A/B capture from switches, execution and result hold. It replaces the raw, key-clocked op counter with a synchronous, debounced FSM. It sits between the board pushbuttons/switches and the combinational ALU, driving the ALU's op select and operands and latching its result for display.

Parameters:
NUM_OPS, 6, number of ALU operations; op_sel cycles 0..NUM_OPS-1
OP_W, 4, width of op_sel
DATA_W, 4, operand width
DEB_CYCLES, 500000, clocks a raw key level must be stable before it is accepted (10 ms at 50 MHz)
REPEAT_CYCLES, 25000000, auto-repeat period; used only with KEY_AUTOREPEAT_EN

Ports:
clk  input  1  system clock, all logic on posedge
rst_n  input  1  asynchronous active-low reset
key_next_n  input  1  raw pushbutton, active-low, asynchronous to clk
key_enter_n  input  1  raw pushbutton, active-low, asynchronous to clk
sw_data  input  DATA_W  operand switches
alu_result  input  DATA_W+1  combinational ALU result (carry in MSB)
op_sel  output  OP_W  operation select to ALU
operand_a  output  DATA_W  latched operand A
operand_b  output  DATA_W  latched operand B
result  output  DATA_W+1  latched ALU result
result_valid  output  1  one-cycle pulse when result is updated
state  output  3  current FSM state code, for LEDs

Behaviour:
- Reset (rst_n low, async): state=SEL_OP, op_sel=0, operand_a=0, operand_b=0, result=0, result_valid=0, debounce counters and synchronizers cleared to "released".
- Key path, per key: 2-FF synchronizer -> debounce counter (counter restarts on any change of the synchronized level; debounced level updates only after DEB_CYCLES consecutive equal samples) -> press pulse: exactly one clk-cycle pulse on debounced released->pressed transition. Release produces no pulse. Latency raw press to pulse: 2 + DEB_CYCLES clocks (+-1).
- States (code): SEL_OP=0, LOAD_A=1, LOAD_B=2, EXEC=3, SHOW=4; codes 5-7 unreachable, recover to SEL_OP next cycle.
- SEL_OP: next pulse -> op_sel+1; at NUM_OPS-1 wraps to 0. enter pulse -> LOAD_A.
- LOAD_A: enter -> operand_a<=sw_data, go LOAD_B. next ignored.
- LOAD_B: enter -> operand_b<=sw_data, go EXEC. next ignored.
- EXEC: single cycle allowing ALU to settle on new operands; on this cycle's clock edge result<=alu_result, result_valid=1 for that one cycle, go SHOW. Keys ignored.
- SHOW: result held. enter -> SEL_OP (op_sel kept). next -> LOAD_A (op_sel, operands kept until overwritten).
- Simultaneous next and enter pulses in same cycle: enter wins, next discarded.
- op_sel never exceeds NUM_OPS-1; width arithmetic done in OP_W bits; NUM_OPS must be <= 2^OP_W.
- Reset mid-session: immediate return to reset values; a key held through reset deassertion produces no pulse until released and pressed again.

Optional Feature:
KEY_AUTOREPEAT_EN
- Defined: while debounced key_next stays pressed in SEL_OP, an extra next pulse every REPEAT_CYCLES clocks after the initial pulse; op_sel keeps stepping with wrap. Repeat timer clears on release or state change. key_enter never repeats.
- Undefined: no repeat logic; one pulse per press.

Test Plan:
- DEB_CYCLES=4: 2-cycle glitch on key_next_n -> no pulse, op_sel stays 0; clean 10-cycle press -> op_sel=1 exactly once.
- In SEL_OP, 7 clean next presses with NUM_OPS=6 -> op_sel sequence 1,2,3,4,5,0,1.
- Full session: op_sel=2, enter, sw_data=4'h3 enter, sw_data=4'h5 enter, alu_result=5'h08 -> operand_a=3, operand_b=5, result=8, result_valid high one cycle, state=4.
- Next and enter debounced in same cycle during SEL_OP -> state=1, op_sel unchanged.
- Assert rst_n low during LOAD_B with operand_a=3 -> all outputs 0, state=0 immediately; held key at release of reset -> no pulse.
- With KEY_AUTOREPEAT_EN, REPEAT_CYCLES=20, hold next 70 cycles past debounce -> op_sel advances 4 times (initial + 3 repeats).

Source files
------------

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: debounced pushbutton controller for a user ALU session.
// It steps through op select, operand A capture, operand B capture, one
// execute cycle and a result hold.
//
// Ports:
//   clk, rst_n            system clock, async active-low reset
//   key_next_n            raw pushbutton (active-low, asynchronous)
//   key_enter_n           raw pushbutton (active-low, asynchronous)
//   sw_data[DATA_W]       operand switches
//   alu_result[DATA_W+1]  combinational ALU result, carry in MSB
//   op_sel[OP_W]          ALU operation select
//   operand_a/_b[DATA_W]  latched operands
//   result[DATA_W+1]      latched ALU result
//   result_valid          one-cycle pulse when result is updated
//   state[3]              current FSM state code for LEDs
//
// Optional feature macro: KEY_AUTOREPEAT_EN. When it is defined, holding
// key_next in SEL_OP repeats the next pulse every REPEAT_CYCLES clocks.
module alu_op_sequencer #(
  parameter int unsigned NUM_OPS       = 6,
  parameter int unsigned OP_W          = 4,
  parameter int unsigned DATA_W        = 4,
  parameter int unsigned DEB_CYCLES    = 500000,
  parameter int unsigned REPEAT_CYCLES = 25000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_next_n,
  input  logic              key_enter_n,
  input  logic [DATA_W-1:0] sw_data,
  input  logic [DATA_W:0]   alu_result,
  output logic [OP_W-1:0]   op_sel,
  output logic [DATA_W-1:0] operand_a,
  output logic [DATA_W-1:0] operand_b,
  output logic [DATA_W:0]   result,
  output logic              result_valid,
  output logic [2:0]        state
);

  localparam int unsigned KEY_NEXT  = 0;
  localparam int unsigned KEY_ENTER = 1;
  localparam int unsigned DEB_W     = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [OP_W-1:0]  OP_LAST  = OP_W'(NUM_OPS - 1);

  typedef enum logic [2:0] {
    SEL_OP = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    EXEC   = 3'd3,
    SHOW   = 3'd4
  } state_e;

  // Key conditioning. Bit 0 is next, bit 1 is enter; 1 means released.
  logic [1:0]       key_raw_n;
  logic [1:0]       sync1_q, sync2_q;
  logic [1:0]       deb_q, deb_d;
  logic [1:0]       armed_q, armed_d;
  logic [1:0]       press_c;
  logic [1:0]       fill_q, fill_d;
  logic [DEB_W-1:0] cnt_q [2];
  logic [DEB_W-1:0] cnt_d [2];

  assign key_raw_n = {key_enter_n, key_next_n};

  // fill_q marks when sync2 holds real samples after reset. A key is only
  // armed after a genuine released sample, so a key held through reset
  // stays silent until it is released and pressed again.
  always_comb begin
    fill_d  = fill_q;
    deb_d   = deb_q;
    armed_d = armed_q;
    press_c = '0;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = cnt_q[i];
    end
    if (fill_q != 2'd2) begin
      fill_d = fill_q + 2'd1;
    end
    for (int i = 0; i < 2; i++) begin
      if (fill_q == 2'd2 && sync2_q[i]) begin
        armed_d[i] = 1'b1;
      end
      if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DEB_LAST) begin
        cnt_d[i]   = '0;
        deb_d[i]   = sync2_q[i];
        press_c[i] = armed_q[i] & ~sync2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + DEB_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 2'b11;
      sync2_q  <= 2'b11;
      deb_q    <= 2'b11;
      armed_q  <= 2'b00;
      fill_q   <= 2'd0;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      sync1_q  <= key_raw_n;
      sync2_q  <= sync1_q;
      deb_q    <= deb_d;
      armed_q  <= armed_d;
      fill_q   <= fill_d;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
    end
  end

  state_e            state_q, state_d;
  logic              next_c;
  logic              enter_c;
  logic [OP_W-1:0]   op_sel_q, op_sel_d;
  logic [DATA_W-1:0] operand_a_q, operand_a_d;
  logic [DATA_W-1:0] operand_b_q, operand_b_d;
  logic [DATA_W:0]   result_q, result_d;
  logic              result_valid_q, result_valid_d;

  assign enter_c = press_c[KEY_ENTER];

`ifdef KEY_AUTOREPEAT_EN
  localparam int unsigned RPT_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

  logic [RPT_W-1:0] rpt_q, rpt_d;
  logic             rpt_c;

  // Repeat timer runs only while debounced next is held in SEL_OP. It
  // clears as soon as the key is released or the state changes.
  always_comb begin
    rpt_d = '0;
    rpt_c = 1'b0;
    if (state_q == SEL_OP && !deb_q[KEY_NEXT] && armed_q[KEY_NEXT]) begin
      if (rpt_q == RPT_LAST) begin
        rpt_c = 1'b1;
      end else begin
        rpt_d = rpt_q + RPT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_q <= '0;
    end else begin
      rpt_q <= rpt_d;
    end
  end

  assign next_c = press_c[KEY_NEXT] | rpt_c;
`else
  logic unused_rpt_c;
  assign unused_rpt_c = 1'(REPEAT_CYCLES);
  assign next_c = press_c[KEY_NEXT];
`endif

  // Session FSM. When next and enter arrive together, enter takes priority.
  always_comb begin
    state_d        = state_q;
    op_sel_d       = op_sel_q;
    operand_a_d    = operand_a_q;
    operand_b_d    = operand_b_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    case (state_q)
      SEL_OP: begin
        if (enter_c) begin
          state_d = LOAD_A;
        end else if (next_c) begin
          op_sel_d = (op_sel_q >= OP_LAST) ? '0 : op_sel_q + OP_W'(1);
        end
      end
      LOAD_A: begin
        if (enter_c) begin
          operand_a_d = sw_data;
          state_d     = LOAD_B;
        end
      end
      LOAD_B: begin
        if (enter_c) begin
          operand_b_d = sw_data;
          state_d     = EXEC;
        end
      end
      EXEC: begin
        result_d       = alu_result;
        result_valid_d = 1'b1;
        state_d        = SHOW;
      end
      SHOW: begin
        if (enter_c) begin
          state_d = SEL_OP;
        end else if (next_c) begin
          state_d = LOAD_A;
        end
      end
      default: state_d = SEL_OP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= SEL_OP;
      op_sel_q       <= '0;
      operand_a_q    <= '0;
      operand_b_q    <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      op_sel_q       <= op_sel_d;
      operand_a_q    <= operand_a_d;
      operand_b_q    <= operand_b_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign op_sel       = op_sel_q;
  assign operand_a    = operand_a_q;
  assign operand_b    = operand_b_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign state        = 3'(state_q);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed testbench for alu_op_sequencer with short debounce and repeat
// periods. Expected values are hand-computed from the intended behaviour.
module tb_alu_op_sequencer;

  localparam int unsigned NUM_OPS = 6;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned DATA_W  = 4;
  localparam int unsigned DEB     = 4;
  localparam int unsigned RPT     = 20;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              key_next_n = 1'b1;
  logic              key_enter_n = 1'b1;
  logic [DATA_W-1:0] sw_data = '0;
  logic [DATA_W:0]   alu_result = 5'h08;
  logic [OP_W-1:0]   op_sel;
  logic [DATA_W-1:0] operand_a;
  logic [DATA_W-1:0] operand_b;
  logic [DATA_W:0]   result;
  logic              result_valid;
  logic [2:0]        state;

  int errors   = 0;
  int checks   = 0;
  int rv_count = 0;

  alu_op_sequencer #(
    .NUM_OPS      (NUM_OPS),
    .OP_W         (OP_W),
    .DATA_W       (DATA_W),
    .DEB_CYCLES   (DEB),
    .REPEAT_CYCLES(RPT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_next_n  (key_next_n),
    .key_enter_n (key_enter_n),
    .sw_data     (sw_data),
    .alu_result  (alu_result),
    .op_sel      (op_sel),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .result      (result),
    .result_valid(result_valid),
    .state       (state)
  );

  always #5 clk = ~clk;

  // Count result_valid cycles, sampled away from the active edge.
  always @(negedge clk) begin
    if (result_valid) rv_count++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Hold the selected keys low for 'hold' cycles, then release and let the
  // release debounce settle.
  task automatic press(input bit nxt, input bit ent, input int hold);
    @(negedge clk);
    if (nxt) key_next_n = 1'b0;
    if (ent) key_enter_n = 1'b0;
    repeat (hold) @(negedge clk);
    key_next_n  = 1'b1;
    key_enter_n = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  int seq [7] = '{1, 2, 3, 4, 5, 0, 1};

  initial begin
    repeat (3) @(negedge clk);
    check("rst_state",  32'(state), 32'd0);
    check("rst_op_sel", 32'(op_sel), 32'd0);
    check("rst_a",      32'(operand_a), 32'd0);
    check("rst_b",      32'(operand_b), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_valid",  32'(result_valid), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    press(1'b1, 1'b0, 2);
    check("glitch_op_sel", 32'(op_sel), 32'd0);
    press(1'b1, 1'b0, 10);
    check("clean_op_sel", 32'(op_sel), 32'd1);

    do_reset();
    check("rerst_op_sel", 32'(op_sel), 32'd0);
    for (int i = 0; i < 7; i++) begin
      press(1'b1, 1'b0, 10);
      check($sformatf("wrap_%0d", i), 32'(op_sel), 32'(seq[i]));
    end

    press(1'b1, 1'b0, 10);
    check("sess_op_sel", 32'(op_sel), 32'd2);
    press(1'b0, 1'b1, 10);
    check("sess_loada", 32'(state), 32'd1);
    sw_data = 4'h3;
    press(1'b0, 1'b1, 10);
    check("sess_loadb", 32'(state), 32'd2);
    check("sess_a", 32'(operand_a), 32'd3);
    sw_data  = 4'h5;
    rv_count = 0;
    press(1'b0, 1'b1, 10);
    check("sess_b",        32'(operand_b), 32'd5);
    check("sess_result",   32'(result), 32'h08);
    check("sess_show",     32'(state), 32'd4);
    check("sess_rv_count", 32'(rv_count), 32'd1);
    check("sess_rv_low",   32'(result_valid), 32'd0);
    check("sess_op_kept",  32'(op_sel), 32'd2);

    press(1'b1, 1'b0, 10);
    check("show_next_state", 32'(state), 32'd1);
    check("show_next_a",     32'(operand_a), 32'd3);
    press(1'b1, 1'b0, 10);
    check("loada_next_ign", 32'(state), 32'd1);
    sw_data = 4'h3;
    press(1'b0, 1'b1, 10);
    check("pre_rst_loadb", 32'(state), 32'd2);

    // Reset mid-session with next held through reset release.
    @(negedge clk);
    key_next_n = 1'b0;
    rst_n      = 1'b0;
    #1;
    check("mid_rst_state",  32'(state), 32'd0);
    check("mid_rst_a",      32'(operand_a), 32'd0);
    check("mid_rst_b",      32'(operand_b), 32'd0);
    check("mid_rst_result", 32'(result), 32'd0);
    check("mid_rst_op_sel", 32'(op_sel), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (DEB + 12) @(negedge clk);
    check("held_op_sel", 32'(op_sel), 32'd0);
    check("held_state",  32'(state), 32'd0);
    key_next_n = 1'b1;
    repeat (12) @(negedge clk);
    press(1'b1, 1'b0, 10);
    check("repress_op_sel", 32'(op_sel), 32'd1);

    press(1'b1, 1'b1, 10);
    check("both_state",  32'(state), 32'd1);
    check("both_op_sel", 32'(op_sel), 32'd1);
    press(1'b0, 1'b1, 10);
    press(1'b0, 1'b1, 10);
    check("sess2_show", 32'(state), 32'd4);
    press(1'b0, 1'b1, 10);
    check("show_enter_state",  32'(state), 32'd0);
    check("show_enter_op_sel", 32'(op_sel), 32'd1);

    press(1'b1, 1'b0, DEB + 2 + 70);
`ifdef KEY_AUTOREPEAT_EN
    check("hold_op_sel", 32'(op_sel), 32'd5);
`else
    check("hold_op_sel", 32'(op_sel), 32'd2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
